// File: rtl/audio_info_frame_dynamic.sv
// HDMI Audio InfoFrame source (type 0x84, version 1, length 10) whose
// audio fields can be reconfigured at runtime. A new configuration is
// staged, checked against the committed one, and its checksum is
// accumulated one byte per cycle. The finished frame then replaces the
// registered outputs in one edge, and only while the assembler is not
// holding frame_lock.
module audio_info_frame_dynamic #(
  parameter logic [2:0] DEFAULT_CHANNEL_COUNT      = 3'd1,
  parameter logic [7:0] DEFAULT_CHANNEL_ALLOCATION = 8'h00,
  parameter logic       DEFAULT_DOWN_MIX_INHIBITED = 1'b0,
  parameter logic [3:0] DEFAULT_LEVEL_SHIFT_VALUE  = 4'd0,
  parameter logic [1:0] DEFAULT_LFE_PLAYBACK_LEVEL = 2'b00,
  parameter logic [7:0] MAX_CHANNEL_ALLOCATION     = 8'h31
) (
  input  logic             clk_pixel,
  input  logic             reset,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [2:0]       cfg_channel_count,
  input  logic [7:0]       cfg_channel_allocation,
  input  logic             cfg_down_mix_inhibited,
  input  logic [3:0]       cfg_level_shift_value,
  input  logic [1:0]       cfg_lfe_playback_level,
  input  logic             frame_lock,
  output logic [23:0]      header,
  output logic [3:0][55:0] sub,
  output logic             frame_updated,
  output logic             cfg_error
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SUM    = 2'd1;
  localparam logic [1:0] COMMIT = 2'd2;

  // 8'h84 + 8'h01 + 8'h0A, the header contribution to the checksum
  localparam logic [7:0] HEADER_SUM = 8'h8F;

  localparam logic [7:0] DEFAULT_PB5 = {DEFAULT_DOWN_MIX_INHIBITED, DEFAULT_LEVEL_SHIFT_VALUE,
                                        1'b0, DEFAULT_LFE_PLAYBACK_LEVEL};
  localparam logic [7:0] DEFAULT_SUM = HEADER_SUM + {5'd0, DEFAULT_CHANNEL_COUNT}
                                       + DEFAULT_CHANNEL_ALLOCATION + DEFAULT_PB5;
  localparam logic [7:0] DEFAULT_PB0 = 8'h00 - DEFAULT_SUM;

  // Lays out the 28 payload bytes: only PB0..PB5 can ever be non-zero.
  function automatic logic [3:0][55:0] build_sub(input logic [2:0] cc, input logic [7:0] ca,
                                                 input logic dm, input logic [3:0] lsv,
                                                 input logic [1:0] lfe, input logic [7:0] pb0);
    logic [3:0][55:0] s;
    s = '0;
    s[0][7:0]   = pb0;
    s[0][15:8]  = {5'd0, cc};
    s[0][39:32] = ca;
    s[0][47:40] = {dm, lsv, 1'b0, lfe};
    return s;
  endfunction

  localparam logic [3:0][55:0] DEFAULT_SUB = build_sub(DEFAULT_CHANNEL_COUNT,
      DEFAULT_CHANNEL_ALLOCATION, DEFAULT_DOWN_MIX_INHIBITED, DEFAULT_LEVEL_SHIFT_VALUE,
      DEFAULT_LFE_PLAYBACK_LEVEL, DEFAULT_PB0);

  logic [1:0] state_reg;
  logic       pending_reg;   // fields staged, comparison happens next cycle
  logic [7:0] acc_reg;
  logic [2:0] index_reg;

  // committed fields (what sub currently describes)
  logic [2:0] cc_reg;
  logic [7:0] ca_reg;
  logic       dm_reg;
  logic [3:0] lsv_reg;
  logic [1:0] lfe_reg;

  // staged fields (the candidate frame)
  logic [2:0] cc_stg_reg;
  logic [7:0] ca_stg_reg;
  logic       dm_stg_reg;
  logic [3:0] lsv_stg_reg;
  logic [1:0] lfe_stg_reg;

  logic [7:0] sum_byte;
  logic       same_cfg;

  assign header = 24'h0A0184;

  // Payload byte of the staged frame addressed by the serial checksum index
  always_comb begin
    sum_byte = 8'h00;
    case (index_reg)
      3'd1:    sum_byte = {5'd0, cc_stg_reg};
      3'd4:    sum_byte = ca_stg_reg;
      3'd5:    sum_byte = {dm_stg_reg, lsv_stg_reg, 1'b0, lfe_stg_reg};
      default: sum_byte = 8'h00;
    endcase
  end

  // An unchanged configuration is dropped so the assembler sees no spurious update
  always_comb begin
    same_cfg = (cc_stg_reg == cc_reg) && (ca_stg_reg == ca_reg) && (dm_stg_reg == dm_reg) &&
               (lsv_stg_reg == lsv_reg) && (lfe_stg_reg == lfe_reg);
  end

  // Handshake, serial checksum and atomic commit
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      state_reg     <= IDLE;
      pending_reg   <= 1'b0;
      acc_reg       <= 8'h00;
      index_reg     <= 3'd0;
      cfg_ready     <= 1'b1;
      frame_updated <= 1'b0;
      cfg_error     <= 1'b0;
      sub           <= DEFAULT_SUB;
      cc_reg        <= DEFAULT_CHANNEL_COUNT;
      ca_reg        <= DEFAULT_CHANNEL_ALLOCATION;
      dm_reg        <= DEFAULT_DOWN_MIX_INHIBITED;
      lsv_reg       <= DEFAULT_LEVEL_SHIFT_VALUE;
      lfe_reg       <= DEFAULT_LFE_PLAYBACK_LEVEL;
      cc_stg_reg    <= DEFAULT_CHANNEL_COUNT;
      ca_stg_reg    <= DEFAULT_CHANNEL_ALLOCATION;
      dm_stg_reg    <= DEFAULT_DOWN_MIX_INHIBITED;
      lsv_stg_reg   <= DEFAULT_LEVEL_SHIFT_VALUE;
      lfe_stg_reg   <= DEFAULT_LFE_PLAYBACK_LEVEL;
    end else begin
      frame_updated <= 1'b0;
      cfg_error     <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (pending_reg) begin
            pending_reg <= 1'b0;
            if (same_cfg) begin
              cfg_ready <= 1'b1;
            end else begin
              acc_reg   <= HEADER_SUM;
              index_reg <= 3'd1;
              state_reg <= SUM;
            end
          end else if (cfg_valid && cfg_ready) begin
            // out-of-range allocation is refused without ever leaving IDLE
            if (cfg_channel_allocation > MAX_CHANNEL_ALLOCATION) begin
              cfg_error <= 1'b1;
            end else begin
              cc_stg_reg  <= cfg_channel_count;
              ca_stg_reg  <= cfg_channel_allocation;
              dm_stg_reg  <= cfg_down_mix_inhibited;
              lsv_stg_reg <= cfg_level_shift_value;
              lfe_stg_reg <= cfg_lfe_playback_level;
              pending_reg <= 1'b1;
              cfg_ready   <= 1'b0;
            end
          end
        end
        SUM: begin
          acc_reg   <= acc_reg + sum_byte;
          index_reg <= index_reg + 3'd1;
          if (index_reg == 3'd5) begin
            state_reg <= COMMIT;
          end
        end
        COMMIT: begin
          if (!frame_lock) begin
            sub <= build_sub(cc_stg_reg, ca_stg_reg, dm_stg_reg, lsv_stg_reg, lfe_stg_reg,
                             8'h00 - acc_reg);
            cc_reg        <= cc_stg_reg;
            ca_reg        <= ca_stg_reg;
            dm_reg        <= dm_stg_reg;
            lsv_reg       <= lsv_stg_reg;
            lfe_reg       <= lfe_stg_reg;
            frame_updated <= 1'b1;
            cfg_ready     <= 1'b1;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
